// File: rtl/pwm_breath_seq_if.sv
// Control/status bundle between upper logic and the breathing sequencer.
// Master drives start/stop/config; slave returns duty value and status.
interface pwm_breath_seq_if #(
  parameter int BITS   = 9,
  parameter int HOLD_W = 8
);
  logic              start;
  logic              stop;
  logic [BITS-1:0]   cfg_step;
  logic [HOLD_W-1:0] cfg_hold_hi;
  logic [HOLD_W-1:0] cfg_hold_lo;
  logic [7:0]        cfg_cycles;
  logic [BITS-1:0]   value;
  logic              busy;
  logic              done;
  logic [2:0]        phase;

  modport master (
    output start, stop, cfg_step,
    output cfg_hold_hi, cfg_hold_lo, cfg_cycles,
    input  value, busy, done, phase
  );

  modport slave (
    input  start, stop, cfg_step,
    input  cfg_hold_hi, cfg_hold_lo, cfg_cycles,
    output value, busy, done, phase
  );
endinterface

// File: rtl/pwm_breath_seq.sv
// Breathing-pattern sequencer feeding the PWM duty value.
// Optional PWM_SEQ_SQUARE_EN: registered (level^2)>>BITS output curve.
module pwm_breath_seq #(
  parameter int BITS     = 9,
  parameter int TICK_DIV = 12000,
  parameter int TICK_W   = 14,
  parameter int HOLD_W   = 8
) (
  input logic clk,
  input logic rst,
  pwm_breath_seq_if.slave ctl
);

  localparam logic [BITS-1:0] MAXV = '1;
  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } state_t;

  state_t            r_state, w_state_nx;
  logic [TICK_W-1:0] r_pre, w_pre_nx;
  logic [BITS-1:0]   r_level, w_level_nx;
  logic [BITS-1:0]   r_step, w_step_nx;
  logic [HOLD_W-1:0] r_hold_hi, w_hold_hi_nx;
  logic [HOLD_W-1:0] r_hold_lo, w_hold_lo_nx;
  logic [HOLD_W-1:0] r_hold, w_hold_nx;
  logic [7:0]        r_cycles, w_cycles_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic              r_done, w_done_nx;
  logic              w_tick;
  logic              w_abort;
  logic [BITS:0]     w_sum;
  logic [8:0]        w_cnt_inc;

  assign w_tick    = (r_state != IDLE) &&
                     (r_pre == TICK_LAST);
  assign w_abort   = ctl.stop && (r_state != IDLE);
  assign w_sum     = {1'b0, r_level} + {1'b0, r_step};
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // Next-state and datapath decode; stop overrides everything.
  always_comb begin
    w_state_nx   = r_state;
    w_pre_nx     = '0;
    w_level_nx   = r_level;
    w_step_nx    = r_step;
    w_hold_hi_nx = r_hold_hi;
    w_hold_lo_nx = r_hold_lo;
    w_hold_nx    = r_hold;
    w_cycles_nx  = r_cycles;
    w_cnt_nx     = r_cnt;
    w_done_nx    = 1'b0;

    if (r_state != IDLE && !w_tick)
      w_pre_nx = r_pre + 1'b1;

    case (r_state)
      IDLE: begin
        if (ctl.start && !ctl.stop) begin
          w_step_nx    = (ctl.cfg_step == '0) ?
                         BITS'(1) : ctl.cfg_step;
          w_hold_hi_nx = ctl.cfg_hold_hi;
          w_hold_lo_nx = ctl.cfg_hold_lo;
          w_cycles_nx  = ctl.cfg_cycles;
          w_level_nx   = '0;
          w_cnt_nx     = '0;
          w_state_nx   = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (w_tick) begin
          if (w_sum >= {1'b0, MAXV}) begin
            w_level_nx = MAXV;
            w_hold_nx  = r_hold_hi;
            w_state_nx = HOLD_HI;
          end else begin
            w_level_nx = w_sum[BITS-1:0];
          end
        end
      end
      HOLD_HI: begin
        if (w_tick) begin
          if (r_hold == '0)
            w_state_nx = RAMP_DOWN;
          else
            w_hold_nx = r_hold - 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (w_tick) begin
          if (r_level <= r_step) begin
            w_level_nx = '0;
            w_hold_nx  = r_hold_lo;
            w_state_nx = HOLD_LO;
          end else begin
            w_level_nx = r_level - r_step;
          end
        end
      end
      HOLD_LO: begin
        if (w_tick) begin
          if (r_hold == '0) begin
            w_cnt_nx = w_cnt_inc[8] ?
                       8'hFF : w_cnt_inc[7:0];
            if (r_cycles != '0 &&
                w_cnt_inc == {1'b0, r_cycles}) begin
              w_state_nx = IDLE;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = RAMP_UP;
            end
          end else begin
            w_hold_nx = r_hold - 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_level_nx = '0;
      end
    endcase

    if (w_abort) begin
      w_state_nx = IDLE;
      w_level_nx = '0;
      w_pre_nx   = '0;
      w_done_nx  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_level   <= '0;
      r_step    <= '0;
      r_hold_hi <= '0;
      r_hold_lo <= '0;
      r_hold    <= '0;
      r_cycles  <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pre     <= w_pre_nx;
      r_level   <= w_level_nx;
      r_step    <= w_step_nx;
      r_hold_hi <= w_hold_hi_nx;
      r_hold_lo <= w_hold_lo_nx;
      r_hold    <= w_hold_nx;
      r_cycles  <= w_cycles_nx;
      r_cnt     <= w_cnt_nx;
      r_done    <= w_done_nx;
    end
  end

`ifdef PWM_SEQ_SQUARE_EN
  logic [2*BITS-1:0] w_lvl_w;
  logic [BITS-1:0]   w_sq_hi;
  logic [BITS-1:0]   r_value;

  assign w_lvl_w = {{BITS{1'b0}}, r_level};
  assign w_sq_hi = BITS'((w_lvl_w * w_lvl_w) >> BITS);

  // Perceptual curve: one cycle behind level, cleared with it.
  always_ff @(posedge clk) begin
    if (rst || w_abort)
      r_value <= '0;
    else
      r_value <= w_sq_hi;
  end

  assign ctl.value = r_value;
`else
  assign ctl.value = r_level;
`endif

  assign ctl.busy  = (r_state != IDLE);
  assign ctl.done  = r_done;
  assign ctl.phase = r_state;

endmodule
